// File: rtl/equals_cov_monitor.sv
// ============================================================================
// Module  : equals_cov_monitor
// Brief   : Hardware coverage collector for a 2-bit sample stream: value-bin
//           hit counters, optional transition bins (EQUALS_COV_TRANS_BINS_EN),
//           covered-bin count and a one-shot coverage-complete pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module equals_cov_monitor #(
    parameter int CNT_W    = 8,
    parameter int AT_LEAST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [1:0]       sample_data,
    input  logic             clear,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic [3:0]       val_hit,
    output logic [15:0]      trans_hit,
    output logic [4:0]       bins_covered,
    output logic             cov_done
);

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_at_least = CNT_W'(AT_LEAST);

    localparam logic [1:0] c_st_no_prev   = 2'd0;
    localparam logic [1:0] c_st_track     = 2'd1;
    localparam logic [1:0] c_st_done_hold = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt [4];
    logic             w_capture;
    logic             w_all_cov;
    logic [4:0]       w_pop;

    // A sample coinciding with clear is dropped.
    assign w_capture = sample_valid & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (sample_valid && (r_cnt[sample_data] != c_cnt_max)) begin
            r_cnt[sample_data] <= r_cnt[sample_data] + c_cnt_one;
        end
    end

    always_comb begin
        val_hit = '0;
        for (int i = 0; i < 4; i++) val_hit[i] = (r_cnt[i] >= c_at_least);
    end

    assign rd_count = r_cnt[rd_sel];

`ifdef EQUALS_COV_TRANS_BINS_EN
    logic [1:0]  r_prev;
    logic [15:0] r_trans;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= '0;
            r_trans <= '0;
        end else if (clear) begin
            r_prev  <= '0;
            r_trans <= '0;
        end else if (w_capture) begin
            r_prev <= sample_data;
            // NO_PREV means r_prev holds no real sample yet.
            if (r_state != c_st_no_prev) r_trans[{r_prev, sample_data}] <= 1'b1;
        end
    end

    assign trans_hit = r_trans;
    assign w_all_cov = (&val_hit) & (&r_trans);
`else
    assign trans_hit = '0;
    assign w_all_cov = &val_hit;
`endif

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 4; i++)  w_pop = w_pop + 5'(val_hit[i]);
        for (int i = 0; i < 16; i++) w_pop = w_pop + 5'(trans_hit[i]);
    end

    assign bins_covered = w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_no_prev;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = c_st_no_prev;
        end else begin
            case (r_state)
                c_st_no_prev:   if (sample_valid) w_state_next = c_st_track;
                c_st_track:     if (w_all_cov)    w_state_next = c_st_done_hold;
                c_st_done_hold: w_state_next = c_st_done_hold;
                default:        w_state_next = c_st_no_prev;
            endcase
        end
    end

    // Pulse lasts one cycle: the FSM moves to DONE_HOLD on the following edge.
    assign cov_done = w_all_cov & (r_state != c_st_done_hold);

endmodule

`default_nettype wire
